// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central hazard controller for the 5-stage RV32 pipeline.
//            Produces per-stage stall/flush controls, E-stage forwarding
//            selects and the PC redirect. A single FSM sequences the three
//            multi-cycle events: taken-branch redirect (D flushed for
//            FLUSH_CYCLES cycles), load-use stall (LOAD_LAT cycles) and
//            data-memory wait.
// Ports    : clk                       rising-edge clock
//            rst                       asynchronous reset, active low
//            Rs1D/Rs2D, Rs1E/Rs2E      source registers in D / E
//            RdE/RdM/RdW               destination registers in E/M/W
//            LoadE                     E-stage instruction is a load
//            RegWriteM/RegWriteW       M/W instruction writes the RF
//            PCsrcE/PCtargetE          taken branch/jump and its target
//            mem_busy                  data memory not ready this cycle
//            StallF/D/E/M              hold pipeline register (PC for F)
//            FlushD/E/W                load bubble into D/E/W register
//            ForwardAE/BE              00 RF, 01 W result, 10 M ALU result
//            pc_redirect/pc_target     PC mux select and redirect target
//            ctrl_state                0 RUN, 1 REDIR, 2 LDSTALL, 3 MEMWAIT
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        LoadE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCsrcE,
    input  logic [31:0] PCtargetE,
    input  logic        mem_busy,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [1:0]  ctrl_state
);

    // A length of 0 behaves like 1 (single detect cycle only).
    localparam int         c_FLUSH_EFF  = (FLUSH_CYCLES < 1) ? 1 : FLUSH_CYCLES;
    localparam int         c_LOAD_EFF   = (LOAD_LAT < 1) ? 1 : LOAD_LAT;
    localparam logic [3:0] c_FLUSH_INIT = 4'(c_FLUSH_EFF - 1);
    localparam logic [3:0] c_LOAD_INIT  = 4'(c_LOAD_EFF - 1);

    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_REDIR   = 2'd1;
    localparam logic [1:0] c_LDSTALL = 2'd2;
    localparam logic [1:0] c_MEMWAIT = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pc_target;

    logic [1:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] w_target_nxt;
    logic        w_lw_haz;
    logic        w_cnt_last;
    logic        w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic        w_flush_d, w_flush_e, w_flush_w;
    logic        w_redirect;

    // Forwarding: M has the younger result, so it wins over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    assign w_lw_haz   = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_cnt_last = (r_cnt == 4'd1) || (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_pc_target;
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_stall_e    = 1'b0;
        w_stall_m    = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_flush_w    = 1'b0;
        w_redirect   = 1'b0;
        case (r_state)
            c_REDIR: begin
                // E already holds a bubble, so new branches/load hazards are ignored.
                w_flush_d = 1'b1;
                if (mem_busy) begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_w} = 5'b11111;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (w_cnt_last)
                        w_state_nxt = c_RUN;
                end
            end
            c_LDSTALL: begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_flush_e = 1'b1;
                if (mem_busy) begin
                    {w_stall_e, w_stall_m, w_flush_w} = 3'b111;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (w_cnt_last)
                        w_state_nxt = c_RUN;
                end
            end
            default: begin
                // RUN, and MEMWAIT once memory is ready: MEMWAIT only differs
                // from RUN in what it reports on ctrl_state.
                if (mem_busy) begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_w} = 5'b11111;
                    w_state_nxt = c_MEMWAIT;
                end else begin
                    w_state_nxt = c_RUN;
                    if (PCsrcE) begin
                        w_redirect   = 1'b1;
                        w_target_nxt = PCtargetE;
                        w_flush_d    = 1'b1;
                        w_flush_e    = 1'b1;
                        if (c_FLUSH_EFF > 1) begin
                            w_cnt_nxt   = c_FLUSH_INIT;
                            w_state_nxt = c_REDIR;
                        end
                    end else if (w_lw_haz) begin
                        w_stall_f = 1'b1;
                        w_stall_d = 1'b1;
                        w_flush_e = 1'b1;
                        if (c_LOAD_EFF > 1) begin
                            w_cnt_nxt   = c_LOAD_INIT;
                            w_state_nxt = c_LDSTALL;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_RUN;
            r_cnt       <= 4'd0;
            r_pc_target <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pc_target <= w_target_nxt;
        end
    end

    // Controls are forced low for as long as reset is held, independent of inputs.
    assign StallF      = rst & w_stall_f;
    assign StallD      = rst & w_stall_d;
    assign StallE      = rst & w_stall_e;
    assign StallM      = rst & w_stall_m;
    assign FlushD      = rst & w_flush_d;
    assign FlushE      = rst & w_flush_e;
    assign FlushW      = rst & w_flush_w;
    assign pc_redirect = rst & w_redirect;
    assign pc_target   = !rst ? 32'd0 : (w_redirect ? PCtargetE : r_pc_target);
    assign ctrl_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench. Three controller instances with different
//            lengths (2/1, 3/3, 0/0) share one stimulus; each is compared
//            every cycle against a remaining-cycles model, with directed
//            literal checks on branch, load-use, memory-wait and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int NI = 3;

    // Control bit layout used by the bench: {SF,SD,SE,SM,FD,FE,FW,PR}
    localparam logic [7:0] B_SF = 8'h80, B_SD = 8'h40, B_SE = 8'h20, B_SM = 8'h10;
    localparam logic [7:0] B_FD = 8'h08, B_FE = 8'h04, B_FW = 8'h02, B_PR = 8'h01;
    localparam logic [7:0] B_MEM = B_SF | B_SD | B_SE | B_SM | B_FW;

    function automatic int fc_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int ll_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        LoadE, RegWriteM, RegWriteW, PCsrcE, mem_busy;
    logic [31:0] PCtargetE;

    logic [NI-1:0] StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, pc_redirect;
    logic [1:0]    fae [NI];
    logic [1:0]    fbe [NI];
    logic [1:0]    cst [NI];
    logic [31:0]   ptg [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipeline_hazard_ctrl #(
            .FLUSH_CYCLES(fc_of(g)),
            .LOAD_LAT    (ll_of(g))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .Rs1D       (Rs1D),
            .Rs2D       (Rs2D),
            .Rs1E       (Rs1E),
            .Rs2E       (Rs2E),
            .RdE        (RdE),
            .RdM        (RdM),
            .RdW        (RdW),
            .LoadE      (LoadE),
            .RegWriteM  (RegWriteM),
            .RegWriteW  (RegWriteW),
            .PCsrcE     (PCsrcE),
            .PCtargetE  (PCtargetE),
            .mem_busy   (mem_busy),
            .StallF     (StallF[g]),
            .StallD     (StallD[g]),
            .StallE     (StallE[g]),
            .StallM     (StallM[g]),
            .FlushD     (FlushD[g]),
            .FlushE     (FlushE[g]),
            .FlushW     (FlushW[g]),
            .ForwardAE  (fae[g]),
            .ForwardBE  (fbe[g]),
            .pc_redirect(pc_redirect[g]),
            .pc_target  (ptg[g]),
            .ctrl_state (cst[g])
        );
    end

    function automatic logic [7:0] ctl_of(input int i);
        return {StallF[i], StallD[i], StallE[i], StallM[i],
                FlushD[i], FlushE[i], FlushW[i], pc_redirect[i]};
    endfunction

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: cycles of redirect / load stall still owed, plus a "waiting on
    // memory" flag that only affects the reported state.
    int          redir_left [NI];
    int          ld_left    [NI];
    bit          waiting    [NI];
    logic [31:0] mtgt       [NI];
    int          n_redir    [NI];
    int          n_ld       [NI];
    bit          n_wait     [NI];
    logic [31:0] n_tgt      [NI];

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            redir_left[i] = 0; ld_left[i] = 0; waiting[i] = 0; mtgt[i] = 0;
            n_redir[i] = 0; n_ld[i] = 0; n_wait[i] = 0; n_tgt[i] = 0;
        end
    endtask

    // Compare all instances against the model at the current input values.
    task automatic compare_now();
        logic [7:0]  e_ctl;
        logic [1:0]  e_st;
        logic [31:0] e_tgt;
        bit          lw;
        int          fc_e, ll_e;
        lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        for (int i = 0; i < NI; i++) begin
            fc_e = (fc_of(i) < 1) ? 1 : fc_of(i);
            ll_e = (ll_of(i) < 1) ? 1 : ll_of(i);
            e_ctl = 8'h00;
            e_st  = 2'd0;
            if (!rst) begin
                redir_left[i] = 0; ld_left[i] = 0; waiting[i] = 0; mtgt[i] = 0;
                n_redir[i] = 0; n_ld[i] = 0; n_wait[i] = 0; n_tgt[i] = 0;
                e_tgt = 32'd0;
            end else begin
                n_redir[i] = redir_left[i];
                n_ld[i]    = ld_left[i];
                n_wait[i]  = waiting[i];
                n_tgt[i]   = mtgt[i];
                if (redir_left[i] > 0) begin
                    e_st  = 2'd1;
                    e_ctl = B_FD;
                    if (mem_busy) e_ctl |= B_MEM;
                    else          n_redir[i] = redir_left[i] - 1;
                end else if (ld_left[i] > 0) begin
                    e_st  = 2'd2;
                    e_ctl = B_SF | B_SD | B_FE;
                    if (mem_busy) e_ctl |= B_SE | B_SM | B_FW;
                    else          n_ld[i] = ld_left[i] - 1;
                end else begin
                    e_st = waiting[i] ? 2'd3 : 2'd0;
                    if (mem_busy) begin
                        e_ctl     = B_MEM;
                        n_wait[i] = 1;
                    end else begin
                        n_wait[i] = 0;
                        if (PCsrcE) begin
                            e_ctl      = B_PR | B_FD | B_FE;
                            n_tgt[i]   = PCtargetE;
                            n_redir[i] = fc_e - 1;
                        end else if (lw) begin
                            e_ctl   = B_SF | B_SD | B_FE;
                            n_ld[i] = ll_e - 1;
                        end
                    end
                end
                e_tgt = (e_ctl & B_PR) != 0 ? PCtargetE : mtgt[i];
            end
            chk($sformatf("ctl[%0d]", i),   ctl_of(i), e_ctl);
            chk($sformatf("state[%0d]", i), cst[i],    e_st);
            chk($sformatf("target[%0d]", i), ptg[i],   e_tgt);
            chk($sformatf("fwdA[%0d]", i),  fae[i],    fwd(Rs1E));
            chk($sformatf("fwdB[%0d]", i),  fbe[i],    fwd(Rs2E));
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare_now();
    endtask

    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            redir_left[i] = n_redir[i];
            ld_left[i]    = n_ld[i];
            waiting[i]    = n_wait[i];
            mtgt[i]       = n_tgt[i];
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCsrcE = 0; mem_busy = 0;
        PCtargetE = 0;
    endtask

    initial begin
        model_clear();
        clear_inputs();
        rst = 1'b0;
        // Reset state, with inputs that would otherwise trigger events.
        PCsrcE = 1; PCtargetE = 32'h1234; mem_busy = 1;
        settle();
        chk("reset ctl", ctl_of(0), 8'h00);
        chk("reset target", ptg[0], 32'd0);
        chk("reset state", cst[0], 2'd0);
        advance();
        clear_inputs();
        cycle();
        rst = 1'b1;
        cycle();

        // T1 forwarding
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
        settle();
        chk("T1 fwdA M", fae[0], 2'b10);
        chk("T1 fwdB zero", fbe[0], 2'b00);
        advance();
        RdM = 0;
        settle();
        chk("T1 fwdA W", fae[0], 2'b01);
        advance();
        Rs2E = 0; RdW = 0;
        settle();
        chk("T1 fwdB RF", fbe[0], 2'b00);
        advance();
        clear_inputs();

        // T2 load-use, LOAD_LAT=1
        LoadE = 1; RdE = 7; Rs2D = 7;
        settle();
        chk("T2 stall", ctl_of(0), B_SF | B_SD | B_FE);
        advance();
        LoadE = 0;
        settle();
        chk("T2 after", ctl_of(0), 8'h00);
        advance();
        clear_inputs();
        repeat (4) cycle();

        // T3 taken branch, FLUSH_CYCLES=2
        PCsrcE = 1; PCtargetE = 32'h0000_0100;
        settle();
        chk("T3 detect ctl", ctl_of(0), B_PR | B_FD | B_FE);
        chk("T3 detect target", ptg[0], 32'h100);
        advance();
        PCsrcE = 0; PCtargetE = 32'hDEAD_BEEF;
        settle();
        chk("T3 c1 ctl", ctl_of(0), B_FD);
        chk("T3 c1 state", cst[0], 2'd1);
        chk("T3 c1 target held", ptg[0], 32'h100);
        advance();
        settle();
        chk("T3 c2 ctl", ctl_of(0), 8'h00);
        chk("T3 c2 state", cst[0], 2'd0);
        advance();
        clear_inputs();
        repeat (3) cycle();

        // T4 memory wait with a branch held
        PCsrcE = 1; PCtargetE = 32'h200; mem_busy = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("T4 wait%0d", k), ctl_of(0), B_MEM);
            advance();
        end
        mem_busy = 0;
        settle();
        chk("T4 redirect", ctl_of(0), B_PR | B_FD | B_FE);
        advance();
        clear_inputs();
        repeat (3) cycle();

        // T5 memory wait inside REDIR freezes the count
        PCsrcE = 1; PCtargetE = 32'h300;
        cycle();
        PCsrcE = 0; mem_busy = 1;
        settle();
        chk("T5 busy1 ctl", ctl_of(0), B_MEM | B_FD);
        advance();
        settle();
        chk("T5 busy2 ctl", ctl_of(0), B_MEM | B_FD);
        advance();
        mem_busy = 0;
        settle();
        chk("T5 last FlushD", ctl_of(0), B_FD);
        chk("T5 last state", cst[0], 2'd1);
        advance();
        settle();
        chk("T5 done", ctl_of(0), 8'h00);
        advance();
        clear_inputs();
        repeat (3) cycle();

        // T6 reset during LDSTALL on the LOAD_LAT=3 instance
        LoadE = 1; RdE = 7; Rs1D = 7;
        cycle();
        LoadE = 0;
        settle();
        chk("T6 in ldstall", cst[1], 2'd2);
        rst = 1'b0;
        #1;
        chk("T6 rst ctl", ctl_of(1), 8'h00);
        chk("T6 rst state", cst[1], 2'd0);
        settle();
        advance();
        rst = 1'b1;
        settle();
        chk("T6 after release", cst[1], 2'd0);
        advance();
        clear_inputs();

        // Randomised phase
        for (int n = 0; n < 3000; n++) begin
            Rs1D      = 5'($urandom_range(0, 3));
            Rs2D      = 5'($urandom_range(0, 3));
            Rs1E      = 5'($urandom_range(0, 3));
            Rs2E      = 5'($urandom_range(0, 3));
            RdE       = 5'($urandom_range(0, 3));
            RdM       = 5'($urandom_range(0, 3));
            RdW       = 5'($urandom_range(0, 3));
            LoadE     = ($urandom_range(0, 9) < 4);
            RegWriteM = $urandom_range(0, 1) == 1;
            RegWriteW = $urandom_range(0, 1) == 1;
            PCsrcE    = ($urandom_range(0, 9) < 2);
            mem_busy  = ($urandom_range(0, 9) < 2);
            PCtargetE = $urandom;
            rst       = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
